// File: rtl/io_bank_pkg.sv
// Shared constants for the memory-mapped I/O bank: window size, offset map
// and the decode regions selected by the top two offset bits.
package io_bank_pkg;

  localparam int WINDOW_BYTES = 128;
  localparam int OFS_W        = $clog2(WINDOW_BYTES);
  localparam int IDX_W        = 3;

  localparam logic [OFS_W-1:0] OFS_OUT    = 7'h00;
  localparam logic [OFS_W-1:0] OFS_SET    = 7'h20;
  localparam logic [OFS_W-1:0] OFS_IN     = 7'h40;
  localparam logic [OFS_W-1:0] OFS_STATUS = 7'h60;
  localparam logic [OFS_W-1:0] OFS_MASK   = 7'h64;

  typedef enum logic [1:0] {
    RGN_OUT = 2'd0,
    RGN_SET = 2'd1,
    RGN_IN  = 2'd2,
    RGN_CTL = 2'd3
  } region_e;

endpackage

// File: rtl/io_sync_edge.sv
// Multi-flop synchroniser for one input word, plus a history register so a
// change of the synchronised value can be flagged for one cycle.
module io_sync_edge #(
  parameter int W      = 32,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] sync,
  output logic         chg
);

  logic [W-1:0] stage_q [STAGES];
  logic [W-1:0] prev_q;

  // NOTE: non-blocking assignments let the chain shift one stage per edge
  // regardless of statement order; blocking would collapse it to one flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
      prev_q <= '0;
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
      prev_q <= stage_q[STAGES-1];
    end
  end

  assign sync = stage_q[STAGES-1];
  assign chg  = (stage_q[STAGES-1] != prev_q);

endmodule

// File: rtl/io_port_bank.sv
// Memory-mapped I/O bank: output registers with OR-set aliases, synchronised
// inputs with sticky W1C change flags, an interrupt mask and a registered IRQ.
module io_port_bank
  import io_bank_pkg::*;
#(
  parameter int          DATA_WIDTH  = 32,
  parameter int          N_OUT       = 4,
  parameter int          N_IN        = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h003F_FF80,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        Write_Enable_i,
  input  logic [31:0]                 Address_i,
  input  logic [DATA_WIDTH-1:0]       Write_Data,
  output logic [DATA_WIDTH-1:0]       Read_Data,
  output logic                        Hit_o,
  output logic [N_OUT*DATA_WIDTH-1:0] OutPorts,
  input  logic [N_IN*DATA_WIDTH-1:0]  InPorts,
  output logic                        Irq_o
);

  logic [OFS_W-1:0]      ofs;
  logic [IDX_W-1:0]      idx;
  region_e               rgn;
  logic                  we;
  logic                  unused_addr;

  logic [DATA_WIDTH-1:0] out_q   [N_OUT];
  logic [DATA_WIDTH-1:0] in_sync [N_IN];
  logic [N_IN-1:0]       chg;
  logic [N_IN-1:0]       status_q, status_next, clr;
  logic [N_IN-1:0]       mask_q, mask_next;
  logic                  irq_q;

  // Byte lanes are ignored: every register is a full word.
  assign ofs         = {Address_i[OFS_W-1:2], 2'b00};
  assign idx         = ofs[2 +: IDX_W];
  assign rgn         = region_e'(ofs[OFS_W-1 -: 2]);
  assign unused_addr = ^Address_i[1:0];
  assign Hit_o       = (Address_i[31:OFS_W] == BASE_ADDR[31:OFS_W]);
  assign we          = Write_Enable_i & Hit_o;

  for (genvar j = 0; j < N_IN; j++) begin : g_in
    io_sync_edge #(
      .W      (DATA_WIDTH),
      .STAGES (SYNC_STAGES)
    ) u_sync (
      .clk   (CLK),
      .rst_n (RST),
      .din   (InPorts[j*DATA_WIDTH +: DATA_WIDTH]),
      .sync  (in_sync[j]),
      .chg   (chg[j])
    );
  end

  // A fresh change event wins over a same-edge clear, so no event is lost.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    clr       = '0;
    mask_next = mask_q;
    if (we && ofs == OFS_STATUS) clr = Write_Data[N_IN-1:0];
    if (we && ofs == OFS_MASK)   mask_next = Write_Data[N_IN-1:0];
    status_next = chg | (status_q & ~clr);
  end

  // NOTE: the register file is small and drives pins, so it is reset with
  // the rest of the state rather than left to power-up values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < N_OUT; i++) out_q[i] <= '0;
      status_q <= '0;
      mask_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      for (int i = 0; i < N_OUT; i++) begin
        if (we && idx == IDX_W'(i)) begin
          if (rgn == RGN_OUT)      out_q[i] <= Write_Data;
          else if (rgn == RGN_SET) out_q[i] <= out_q[i] | Write_Data;
        end
      end
      status_q <= status_next;
      mask_q   <= mask_next;
      irq_q    <= |(status_next & mask_next);
    end
  end

  // Combinational read mux; a same-cycle write is not forwarded.
  always_comb begin
    Read_Data = '0;
    if (Hit_o) begin
      case (rgn)
        RGN_OUT: begin
          for (int i = 0; i < N_OUT; i++)
            if (idx == IDX_W'(i)) Read_Data = out_q[i];
        end
        RGN_SET: Read_Data = '0;
        RGN_IN: begin
          for (int j = 0; j < N_IN; j++)
            if (idx == IDX_W'(j)) Read_Data = in_sync[j];
        end
        RGN_CTL: begin
          if (ofs == OFS_STATUS)    Read_Data = DATA_WIDTH'(status_q);
          else if (ofs == OFS_MASK) Read_Data = DATA_WIDTH'(mask_q);
        end
        default: Read_Data = '0;
      endcase
    end
  end

  for (genvar i = 0; i < N_OUT; i++) begin : g_out
    assign OutPorts[i*DATA_WIDTH +: DATA_WIDTH] = out_q[i];
  end

  assign Irq_o = irq_q;

endmodule

// File: tb/tb_io_port_bank.sv
// Self-checking bench for io_port_bank: expectations are queued when stimulus
// is applied and popped against the DUT outputs when they are sampled.
module tb_io_port_bank;

  localparam int DW = 32;
  localparam int NO = 4;
  localparam int NI = 4;

  localparam logic [31:0] A_OUT1   = 32'h003F_FF84;
  localparam logic [31:0] A_OUT3   = 32'h003F_FF8F;
  localparam logic [31:0] A_SET1   = 32'h003F_FFA4;
  localparam logic [31:0] A_IN0    = 32'h003F_FFC0;
  localparam logic [31:0] A_IN2    = 32'h003F_FFC8;
  localparam logic [31:0] A_STATUS = 32'h003F_FFE0;
  localparam logic [31:0] A_MASK   = 32'h003F_FFE4;
  localparam logic [31:0] A_HOLE   = 32'h003F_FFF0;
  localparam logic [31:0] A_OUT0   = 32'h003F_FF80;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              Write_Enable_i = 1'b0;
  logic [31:0]       Address_i = '0;
  logic [DW-1:0]     Write_Data = '0;
  logic [DW-1:0]     Read_Data;
  logic              Hit_o;
  logic [NO*DW-1:0]  OutPorts;
  logic [NI*DW-1:0]  InPorts = '0;
  logic              Irq_o;

  io_port_bank dut (
    .CLK            (CLK),
    .RST            (RST),
    .Write_Enable_i (Write_Enable_i),
    .Address_i      (Address_i),
    .Write_Data     (Write_Data),
    .Read_Data      (Read_Data),
    .Hit_o          (Hit_o),
    .OutPorts       (OutPorts),
    .InPorts        (InPorts),
    .Irq_o          (Irq_o)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string        tag;
    logic [127:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic expect_val(input string tag, input logic [127:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic observe(input logic [127:0] actual);
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 128'(actual), 128'hx);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, actual, e.val);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    Address_i      = a;
    Write_Data     = d;
    Write_Enable_i = 1'b1;
    tick();
    Write_Enable_i = 1'b0;
    Address_i      = '0;
  endtask

  task automatic bus_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    Address_i = a;
    expect_val(tag, 128'(exp));
    #1;
    observe(128'(Read_Data));
  endtask

  task automatic check_outs(input string tag, input logic [127:0] exp);
    expect_val(tag, exp);
    observe(OutPorts);
  endtask

  task automatic check_irq(input string tag, input logic exp);
    expect_val(tag, 128'(exp));
    observe(128'(Irq_o));
  endtask

  logic [127:0] out_exp;

  initial begin
    // Reset and defaults
    repeat (3) tick();
    check_outs("rst_outports_held", '0);
    RST = 1'b1;
    repeat (3) tick();
    check_outs("rst_outports", '0);
    check_irq("rst_irq", 1'b0);
    bus_read("rst_status", A_STATUS, 32'h0);
    expect_val("hit_in_window", 128'd1);
    observe(128'(Hit_o));
    Address_i = 32'h1001_0000;
    #1;
    expect_val("hit_outside", 128'd0);
    observe(128'(Hit_o));
    expect_val("rd_outside", 128'd0);
    observe(128'(Read_Data));

    // Output write, then OR-set through the alias
    bus_write(A_OUT1, 32'h0000_00F0);
    bus_write(A_SET1, 32'h0000_000F);
    out_exp = {32'h0, 32'h0, 32'h0000_00FF, 32'h0};
    check_outs("out_set", out_exp);
    bus_read("set_reads_zero", A_SET1, 32'h0);
    bus_read("out1_read", A_OUT1, 32'h0000_00FF);
    // Top output register, with nonzero byte-lane bits in the address
    bus_write(A_OUT3, 32'h0000_0055);
    out_exp = {32'h0000_0055, 32'h0, 32'h0000_00FF, 32'h0};
    check_outs("out3_write", out_exp);

    // Mask: only the low N_IN bits are kept
    bus_write(A_MASK, 32'hFFFF_FFF4);
    bus_read("mask_read", A_MASK, 32'h0000_0004);

    // Input synchroniser latency and status
    InPorts[2*DW +: DW] = 32'hDEAD_BEEF;
    tick();
    bus_read("in2_edge1", A_IN2, 32'h0);
    tick();
    bus_read("in2_edge2", A_IN2, 32'hDEAD_BEEF);
    bus_read("status_edge2", A_STATUS, 32'h0);
    check_irq("irq_edge2", 1'b0);
    tick();
    bus_read("status_edge3", A_STATUS, 32'h4);
    check_irq("irq_edge3", 1'b1);

    // Write-1-to-clear
    bus_write(A_STATUS, 32'h4);
    bus_read("w1c_status", A_STATUS, 32'h0);
    check_irq("w1c_irq", 1'b0);

    // Change event on the same edge as a clear keeps the flag
    InPorts[2*DW +: DW] = 32'h0000_1234;
    repeat (3) tick();
    bus_read("status_rearm", A_STATUS, 32'h4);
    InPorts[2*DW +: DW] = 32'h0000_5678;
    repeat (2) tick();
    bus_write(A_STATUS, 32'h4);
    bus_read("collide_status", A_STATUS, 32'h4);
    check_irq("collide_irq", 1'b1);
    tick();
    bus_read("collide_sticky", A_STATUS, 32'h4);
    bus_write(A_STATUS, 32'h4);
    bus_read("clear_after", A_STATUS, 32'h0);

    // Read-only, unmapped, out-of-window and non-enabled writes
    bus_write(A_IN0, 32'h0000_1234);
    bus_write(A_HOLE, 32'h0000_1234);
    bus_write(32'h1000_0084, 32'hAAAA_AAAA);
    Address_i  = A_OUT1;
    Write_Data = 32'h5555_5555;
    tick();
    check_outs("no_write_effect", out_exp);
    bus_read("hole_reads_zero", A_HOLE, 32'h0);
    bus_read("in0_unchanged", A_IN0, 32'h0);

    // Async reset while IRQ high and outputs nonzero
    InPorts[2*DW +: DW] = 32'h0;
    repeat (3) tick();
    check_irq("irq_before_rst", 1'b1);
    #2;
    RST = 1'b0;
    #1;
    check_outs("async_rst_outs", '0);
    check_irq("async_rst_irq", 1'b0);
    bus_read("async_rst_mask", A_MASK, 32'h0);

    // Write presented while reset is asserted is discarded
    tick();
    RST = 1'b1;
    tick();
    Address_i      = A_OUT0;
    Write_Data     = 32'h0000_0099;
    Write_Enable_i = 1'b1;
    #2;
    RST = 1'b0;
    tick();
    Write_Enable_i = 1'b0;
    RST = 1'b1;
    repeat (4) tick();
    bus_read("rst_mid_write", A_OUT0, 32'h0);
    bus_read("no_spurious_status", A_STATUS, 32'h0);
    check_irq("no_spurious_irq", 1'b0);

    check("sb_drained", 128'(sb_q.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
